// File: rtl/writeback_stage.sv
// Y86-64 SEQ write-back stage: owns the 16x64 architectural register file and
// commits valE/valM to dstE/dstM on each rising edge.
module writeback_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  icode,
  input  logic [63:0] valM,
  input  logic [63:0] valE,
  input  logic        cond_flag,
  input  logic [3:0]  rA,
  input  logic [3:0]  rB,
  output logic [63:0] reg0,
  output logic [63:0] reg1,
  output logic [63:0] reg2,
  output logic [63:0] reg3,
  output logic [63:0] reg4,
  output logic [63:0] reg5,
  output logic [63:0] reg6,
  output logic [63:0] reg7,
  output logic [63:0] reg8,
  output logic [63:0] reg9,
  output logic [63:0] reg10,
  output logic [63:0] reg11,
  output logic [63:0] reg12,
  output logic [63:0] reg13,
  output logic [63:0] reg14,
  output logic [63:0] reg15
);

  localparam logic [3:0] RNONE = 4'hF;
  localparam logic [3:0] RSP   = 4'h4;

  logic [63:0] rf [16];
  logic [3:0]  dst_e;
  logic [3:0]  dst_m;

  // Operands are only looked at for icodes that use them, so X/Z on an
  // unused specifier never reaches the write decode.
  always_comb begin
    dst_e = RNONE;
    dst_m = RNONE;
    case (icode)
      4'h2: if (cond_flag) dst_e = rB;
      4'h3: dst_e = rB;
      4'h5: dst_m = rA;
      4'h6: dst_e = rB;
      4'h8, 4'h9, 4'hA: dst_e = RSP;
      4'hB: begin
        dst_e = RSP;
        dst_m = rA;
      end
      default: ;
    endcase
  end

  // The valM write is issued last so it takes precedence when dstE == dstM.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) rf[i] <= '0;
    end else begin
      if (dst_e != RNONE) rf[dst_e] <= valE;
      if (dst_m != RNONE) rf[dst_m] <= valM;
    end
  end

  assign reg0  = rf[0];
  assign reg1  = rf[1];
  assign reg2  = rf[2];
  assign reg3  = rf[3];
  assign reg4  = rf[4];
  assign reg5  = rf[5];
  assign reg6  = rf[6];
  assign reg7  = rf[7];
  assign reg8  = rf[8];
  assign reg9  = rf[9];
  assign reg10 = rf[10];
  assign reg11 = rf[11];
  assign reg12 = rf[12];
  assign reg13 = rf[13];
  assign reg14 = rf[14];
  assign reg15 = rf[15];

endmodule

// File: tb/tb_writeback_stage.sv
// Directed, table-driven bench for writeback_stage; each vector is applied for
// one edge and up to two registers are compared against hand-computed values.
module tb_writeback_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  icode;
  logic [63:0] valM;
  logic [63:0] valE;
  logic        cond_flag;
  logic [3:0]  rA;
  logic [3:0]  rB;
  logic [63:0] r [16];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  writeback_stage dut (
    .clk(clk), .rst(rst), .icode(icode), .valM(valM), .valE(valE),
    .cond_flag(cond_flag), .rA(rA), .rB(rB),
    .reg0(r[0]), .reg1(r[1]), .reg2(r[2]), .reg3(r[3]),
    .reg4(r[4]), .reg5(r[5]), .reg6(r[6]), .reg7(r[7]),
    .reg8(r[8]), .reg9(r[9]), .reg10(r[10]), .reg11(r[11]),
    .reg12(r[12]), .reg13(r[13]), .reg14(r[14]), .reg15(r[15])
  );

  typedef struct {
    logic [3:0]  icode;
    logic [3:0]  ra;
    logic [3:0]  rb;
    logic        cond;
    logic [63:0] val_e;
    logic [63:0] val_m;
    int          idx_a;
    logic [63:0] exp_a;
    int          idx_b;
    logic [63:0] exp_b;
  } vec_t;

  localparam int NV = 21;
  vec_t vecs [NV];
  logic [63:0] final_exp [16];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    //              icode  rA     rB     c     valE                   valM                  ia exp_a                 ib exp_b
    vecs[0]  = '{4'h3, 4'bx, 4'h3, 1'b0, 64'd250,               64'bx,                3,  64'd250,              0,  64'd0};
    vecs[1]  = '{4'h2, 4'h0, 4'h2, 1'b1, 64'd200,               64'd1,                2,  64'd200,              3,  64'd250};
    vecs[2]  = '{4'h2, 4'h0, 4'h2, 1'b0, 64'd77,                64'd1,                2,  64'd200,              0,  64'd0};
    vecs[3]  = '{4'h5, 4'h0, 4'h6, 1'b0, 64'd350,               64'd250,              0,  64'd250,              6,  64'd0};
    vecs[4]  = '{4'h8, 4'bx, 4'bx, 1'b0, 64'd500,               64'bx,                4,  64'd500,              1,  64'd0};
    vecs[5]  = '{4'hB, 4'h1, 4'hF, 1'b0, 64'd550,               64'd450,              4,  64'd550,              1,  64'd450};
    vecs[6]  = '{4'hB, 4'h4, 4'hF, 1'b0, 64'd7,                 64'd9,                4,  64'd9,                7,  64'd0};
    vecs[7]  = '{4'h3, 4'hF, 4'hF, 1'b0, 64'd123,               64'd0,                15, 64'd0,                3,  64'd250};
    vecs[8]  = '{4'h4, 4'h5, 4'h6, 1'b0, 64'd11,                64'd12,               5,  64'd0,                6,  64'd0};
    vecs[9]  = '{4'h7, 4'h3, 4'h3, 1'b1, 64'd99,                64'd98,               3,  64'd250,              4,  64'd9};
    vecs[10] = '{4'h6, 4'h2, 4'h7, 1'b0, 64'hDEAD_BEEF_0000_0001, 64'd0,              7,  64'hDEAD_BEEF_0000_0001, 2, 64'd200};
    vecs[11] = '{4'h9, 4'h0, 4'h0, 1'b0, 64'd600,               64'd5,                4,  64'd600,              0,  64'd250};
    vecs[12] = '{4'hA, 4'h0, 4'h9, 1'b0, 64'd608,               64'd5,                4,  64'd608,              9,  64'd0};
    vecs[13] = '{4'h3, 4'h0, 4'h5, 1'b0, 64'd5,                 64'd0,                5,  64'd5,                0,  64'd250};
    vecs[14] = '{4'h5, 4'hF, 4'h0, 1'b0, 64'd3,                 64'd1,                15, 64'd0,                0,  64'd250};
    vecs[15] = '{4'h1, 4'h2, 4'h2, 1'b1, 64'd1,                 64'd1,                2,  64'd200,              4,  64'd608};
    vecs[16] = '{4'h0, 4'h2, 4'h2, 1'b1, 64'd1,                 64'd1,                2,  64'd200,              5,  64'd5};
    vecs[17] = '{4'hC, 4'h0, 4'h0, 1'b1, 64'd77,                64'd78,               0,  64'd250,              4,  64'd608};
    vecs[18] = '{4'h2, 4'h0, 4'hF, 1'b1, 64'd44,                64'd0,                15, 64'd0,                0,  64'd250};
    vecs[19] = '{4'h6, 4'h0, 4'hE, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0,              14, 64'hFFFF_FFFF_FFFF_FFFF, 0, 64'd250};
    vecs[20] = '{4'hB, 4'hA, 4'h0, 1'b0, 64'd700,               64'h1234,             10, 64'h1234,             4,  64'd700};

    final_exp = '{64'd250, 64'd450, 64'd200, 64'd250, 64'd700, 64'd5, 64'd0,
                  64'hDEAD_BEEF_0000_0001, 64'd0, 64'd0, 64'h1234, 64'd0, 64'd0,
                  64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0};

    rst = 1'b1; icode = 4'h1; valM = '0; valE = '0; cond_flag = 1'b0; rA = 4'hF; rB = 4'hF;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 16; i++) chk($sformatf("reset_reg%0d", i), r[i], 64'd0);

    for (int v = 0; v < NV; v++) begin
      @(negedge clk);
      icode = vecs[v].icode; rA = vecs[v].ra; rB = vecs[v].rb;
      cond_flag = vecs[v].cond; valE = vecs[v].val_e; valM = vecs[v].val_m;
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d_reg%0d", v, vecs[v].idx_a), r[vecs[v].idx_a], vecs[v].exp_a);
      chk($sformatf("vec%0d_reg%0d", v, vecs[v].idx_b), r[vecs[v].idx_b], vecs[v].exp_b);
    end

    @(negedge clk);
    icode = 4'h1;
    for (int i = 0; i < 16; i++) chk($sformatf("final_reg%0d", i), r[i], final_exp[i]);

    // No combinational path: a pending write is invisible until its edge.
    @(negedge clk);
    icode = 4'h3; rB = 4'h8; valE = 64'd4242;
    #2;
    chk("comb_path_reg8", r[8], 64'd0);
    @(posedge clk);
    #1;
    chk("latency_reg8", r[8], 64'd4242);

    // Reset overrides a write in the same cycle.
    @(negedge clk);
    rst = 1'b1; icode = 4'h3; rB = 4'h3; valE = 64'd999;
    @(posedge clk);
    #1;
    rst = 1'b0; icode = 4'h1;
    for (int i = 0; i < 16; i++) chk($sformatf("rst2_reg%0d", i), r[i], 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
